wb_ram_arbiter: RTL and testbench

Two-master Wishbone arbiter that shares the single slave port of the RAM interface block between the instruction-fetch master (m0) and the data/debug master (m1). Round-robin on ties, grant locked for the whole `cyc` of the winner, and a per-transfer timeout that aborts a stalled slave with an error to the granted master. Sits directly in front of the IRAM/DRAM Wishbone-to-RAM bridge on the core clock.

---
 rtl/wb_ram_arbiter.sv | 132 +++++++++++++
 tb/tb_wb_ram_arbiter.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_ram_arbiter.sv
// Two-master Wishbone arbiter in front of the RAM bridge: round-robin on ties, grant locked for
// the owner's whole cycle, and a stall timeout that errors the owner and drains its cycle.
module wb_ram_arbiter #(
  parameter int unsigned WB_ADDR_WIDTH  = 32,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                       wb_clk_i,
  input  logic                       wb_rst_i,
  input  logic [1:0]                 m_cyc_i,
  input  logic [1:0]                 m_stb_i,
  input  logic [1:0]                 m_we_i,
  input  logic [2*WB_ADDR_WIDTH-1:0] m_addr_i,
  input  logic [63:0]                m_wdata_i,
  output logic [63:0]                m_rdata_o,
  output logic [1:0]                 m_ack_o,
  output logic [1:0]                 m_err_o,
  output logic                       s_cyc_o,
  output logic                       s_stb_o,
  output logic                       s_we_o,
  output logic [WB_ADDR_WIDTH-1:0]   s_addr_o,
  output logic [31:0]                s_wdata_o,
  input  logic [31:0]                s_rdata_i,
  input  logic                       s_ack_i,
  output logic                       grant_o,
  output logic                       busy_o
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CntW-1:0] TmoLast = CntW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StBusy, StDrain} state_e;

  state_e          state_q, state_d;
  logic            grant_q, grant_d;
  logic            last_q, last_d;
  logic [CntW-1:0] tmo_q, tmo_d;

  logic [1:0]               req;
  logic                     cyc_sel, stb_sel, we_sel;
  logic [WB_ADDR_WIDTH-1:0] addr_sel;
  logic [31:0]              wdata_sel;
  logic [1:0]               owner_vec;
  logic [63:0]              rdata_vec;

  assign req       = m_cyc_i & m_stb_i;
  assign cyc_sel   = m_cyc_i[grant_q];
  assign stb_sel   = m_stb_i[grant_q];
  assign we_sel    = m_we_i[grant_q];
  assign addr_sel  = grant_q ? m_addr_i[2*WB_ADDR_WIDTH-1:WB_ADDR_WIDTH]
                             : m_addr_i[WB_ADDR_WIDTH-1:0];
  assign wdata_sel = grant_q ? m_wdata_i[63:32] : m_wdata_i[31:0];
  assign owner_vec = grant_q ? 2'b10 : 2'b01;
  assign rdata_vec = grant_q ? {s_rdata_i, 32'h0} : {32'h0, s_rdata_i};

  assign grant_o = grant_q;
  assign busy_o  = (state_q != StIdle);

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= StIdle;
      grant_q <= 1'b0;
      last_q  <= 1'b1;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      tmo_q   <= tmo_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    last_d    = last_q;
    tmo_d     = tmo_q;
    s_cyc_o   = 1'b0;
    s_stb_o   = 1'b0;
    s_we_o    = 1'b0;
    s_addr_o  = '0;
    s_wdata_o = '0;
    m_ack_o   = 2'b00;
    m_err_o   = 2'b00;
    m_rdata_o = '0;

    unique case (state_q)
      StIdle: begin
        if (req != 2'b00) begin
          grant_d = (req == 2'b11) ? ~last_q : req[1];
          tmo_d   = '0;
          state_d = StBusy;
        end
      end

      StBusy: begin
        s_cyc_o   = cyc_sel;
        s_stb_o   = stb_sel;
        s_we_o    = we_sel;
        s_addr_o  = addr_sel;
        s_wdata_o = wdata_sel;
        // An ack in the same cycle the owner drops cyc is still delivered.
        m_ack_o   = s_ack_i ? owner_vec : 2'b00;
        m_rdata_o = rdata_vec;
        if (!cyc_sel) begin
          state_d = StIdle;
          last_d  = grant_q;
          tmo_d   = '0;
        end else if (stb_sel && !s_ack_i) begin
          if (tmo_q == TmoLast) begin
            m_err_o = owner_vec;
            tmo_d   = '0;
            state_d = StDrain;
          end else begin
            tmo_d = tmo_q + 1'b1;
          end
        end else begin
          tmo_d = '0;
        end
      end

      StDrain: begin
        if (!cyc_sel) begin
          state_d = StIdle;
          last_d  = grant_q;
        end
      end

      default: state_d = StIdle;
    endcase
  end

endmodule

// File: tb/tb_wb_ram_arbiter.sv
// Scoreboard bench for wb_ram_arbiter: directed master/slave stimulus, expected slave transfers
// and errors queued in order, a negedge monitor pops and compares them.
module tb_wb_ram_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  m_cyc = '0, m_stb = '0, m_we = '0;
  logic [63:0] m_addr = '0, m_wdata = '0;
  logic [63:0] m_rdata_o;
  logic [1:0]  m_ack_o, m_err_o;
  logic        s_cyc_o, s_stb_o, s_we_o;
  logic [31:0] s_addr_o, s_wdata_o;
  logic [31:0] s_rdata_i = '0;
  logic        s_ack_i = 1'b0;
  logic        grant_o, busy_o;

  wb_ram_arbiter #(.WB_ADDR_WIDTH(32), .TIMEOUT_CYCLES(16)) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .m_cyc_i  (m_cyc),
    .m_stb_i  (m_stb),
    .m_we_i   (m_we),
    .m_addr_i (m_addr),
    .m_wdata_i(m_wdata),
    .m_rdata_o(m_rdata_o),
    .m_ack_o  (m_ack_o),
    .m_err_o  (m_err_o),
    .s_cyc_o  (s_cyc_o),
    .s_stb_o  (s_stb_o),
    .s_we_o   (s_we_o),
    .s_addr_o (s_addr_o),
    .s_wdata_o(s_wdata_o),
    .s_rdata_i(s_rdata_i),
    .s_ack_i  (s_ack_i),
    .grant_o  (grant_o),
    .busy_o   (busy_o)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc_n = 0;
  always @(posedge clk) cyc_n = cyc_n + 1;

  typedef struct {
    bit          err;
    bit          g;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [63:0] rdata;
  } exp_t;
  exp_t sb[$];

  int rise_cyc[$];
  int rise_g[$];
  int fall_cyc[$];
  logic prev_scyc = 1'b0;

  // Slave model: acks after slave_lat stalled cycles; late_ack drives ack while not transferring.
  bit          slave_en = 1'b0;
  int          slave_lat = 1;
  int          scnt = 0;
  bit          late_ack = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_x(input bit err, input bit g, input bit we, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] rd);
    exp_t e;
    e.err = err; e.g = g; e.we = we; e.addr = a; e.wdata = wd;
    e.rdata = g ? {rd, 32'h0} : {32'h0, rd};
    sb.push_back(e);
  endtask

  task automatic drive(input int i, input logic c, input logic s, input logic w,
                       input logic [31:0] a, input logic [31:0] d);
    m_cyc[i] = c;
    m_stb[i] = s;
    m_we[i]  = w;
    if (i == 0) begin
      m_addr[31:0]  = a;
      m_wdata[31:0] = d;
    end else begin
      m_addr[63:32]  = a;
      m_wdata[63:32] = d;
    end
  endtask

  // Called just after a rising edge; holds cyc across nstb acked strobes, then idles one cycle.
  task automatic mxfer(input int i, input logic [31:0] a, input logic w, input logic [31:0] d,
                       input int nstb, output int ack_cyc);
    bit got;
    ack_cyc = -1;
    drive(i, 1'b1, 1'b1, w, a, d);
    for (int k = 0; k < nstb; k++) begin
      got = 1'b0;
      for (int t = 0; t < 200 && !got; t++) begin
        @(negedge clk);
        if (m_ack_o[i] || m_err_o[i]) begin
          got = 1'b1;
          ack_cyc = cyc_n;
        end
      end
      if (!got) check($sformatf("ack_wait_m%0d", i), 64'd0, 64'd1);
      @(posedge clk); #1;
      if (k == nstb - 1) drive(i, 1'b0, 1'b0, w, a, d);
    end
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    forever begin
      @(posedge clk); #2;
      if (slave_en && s_cyc_o && s_stb_o) begin
        if (scnt == slave_lat) begin
          s_ack_i = 1'b1;
          scnt = 0;
        end else begin
          s_ack_i = 1'b0;
          scnt++;
        end
      end else begin
        s_ack_i = late_ack;
        scnt = 0;
      end
    end
  end

  // Monitor: logs slave ownership edges and scores every completed transfer or error.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (s_cyc_o && !prev_scyc) begin
        rise_cyc.push_back(cyc_n);
        rise_g.push_back(int'(grant_o));
      end
      if (!s_cyc_o && prev_scyc) fall_cyc.push_back(cyc_n);
      if ((s_cyc_o && s_stb_o && s_ack_i) || (m_err_o != 2'b00)) begin
        if (sb.size() == 0) begin
          check("sb_unexpected", {62'd0, m_err_o}, 64'd0);
        end else begin
          e = sb.pop_front();
          check("sb_kind_err", {63'd0, m_err_o != 2'b00}, {63'd0, e.err});
          check("sb_grant", {63'd0, grant_o}, {63'd0, e.g});
          if (e.err) begin
            check("sb_err", {62'd0, m_err_o}, e.g ? 64'd2 : 64'd1);
            check("sb_err_noack", {62'd0, m_ack_o}, 64'd0);
          end else begin
            check("sb_ack", {62'd0, m_ack_o}, e.g ? 64'd2 : 64'd1);
            check("sb_we", {63'd0, s_we_o}, {63'd0, e.we});
            check("sb_addr", {32'd0, s_addr_o}, {32'd0, e.addr});
            check("sb_wdata", {32'd0, s_wdata_o}, {32'd0, e.wdata});
            check("sb_rdata", m_rdata_o, e.rdata);
          end
        end
      end
      if (s_ack_i && !(s_cyc_o && s_stb_o)) check("stray_ack", {62'd0, m_ack_o}, 64'd0);
    end
    prev_scyc = rst ? 1'b0 : s_cyc_o;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, k, f, ac, e, r;
    do_reset();
    @(negedge clk);
    check("rst_outputs", {m_rdata_o[31:0], 26'd0, m_ack_o, m_err_o, grant_o, busy_o},
          64'd0);
    check("rst_slave", {27'd0, s_cyc_o, s_stb_o, s_we_o, s_addr_o}, 64'd0);

    // m0 read, slave acks two cycles after strobe.
    @(posedge clk); #1;
    slave_en = 1'b1; slave_lat = 2; s_rdata_i = 32'hDEADBEEF;
    push_x(0, 0, 0, 32'h0000_2004, 32'h0, 32'hDEADBEEF);
    n = cyc_n; k = rise_cyc.size();
    mxfer(0, 32'h0000_2004, 1'b0, 32'h0, 1, ac);
    check("t1_latency", 64'(rise_cyc[k]), 64'(n + 1));
    check("t1_ack_cycle", 64'(ac), 64'(n + 3));

    // m1 write.
    slave_lat = 1; s_rdata_i = 32'hA5A5_0001;
    push_x(0, 1, 1, 32'h0000_0010, 32'h1234_5678, 32'hA5A5_0001);
    mxfer(1, 32'h0000_0010, 1'b1, 32'h1234_5678, 1, ac);

    // Both request continuously after reset: grants alternate.
    do_reset();
    s_rdata_i = 32'h0000_0BAD;
    push_x(0, 0, 0, 32'h100, 32'h11, 32'h0BAD);
    push_x(0, 1, 1, 32'h200, 32'h22, 32'h0BAD);
    push_x(0, 0, 0, 32'h100, 32'h11, 32'h0BAD);
    push_x(0, 1, 1, 32'h200, 32'h22, 32'h0BAD);
    k = rise_cyc.size(); f = fall_cyc.size();
    fork
      begin
        mxfer(0, 32'h100, 1'b0, 32'h11, 1, ac);
        mxfer(0, 32'h100, 1'b0, 32'h11, 1, ac);
      end
      begin
        mxfer(1, 32'h200, 1'b1, 32'h22, 1, ac);
        mxfer(1, 32'h200, 1'b1, 32'h22, 1, ac);
      end
    join
    for (int j = 0; j < 4; j++) check($sformatf("t3_grant%0d", j), 64'(rise_g[k+j]), 64'(j % 2));
    for (int j = 0; j < 3; j++)
      check($sformatf("t3_gap%0d", j), 64'(rise_cyc[k+j+1] - fall_cyc[f+j]), 64'd2);

    // m1 locks the slave over three strobes while m0 waits.
    s_rdata_i = 32'hCAFE_0004;
    push_x(0, 1, 1, 32'h300, 32'h33, 32'hCAFE_0004);
    push_x(0, 1, 1, 32'h300, 32'h33, 32'hCAFE_0004);
    push_x(0, 1, 1, 32'h300, 32'h33, 32'hCAFE_0004);
    push_x(0, 0, 0, 32'h400, 32'h44, 32'hCAFE_0004);
    k = rise_cyc.size(); f = fall_cyc.size();
    fork
      mxfer(1, 32'h300, 1'b1, 32'h33, 3, ac);
      begin
        @(posedge clk); #1;
        mxfer(0, 32'h400, 1'b0, 32'h44, 1, ac);
      end
    join
    check("t4_owner1", 64'(rise_g[k]), 64'd1);
    check("t4_owner0", 64'(rise_g[k+1]), 64'd0);
    check("t4_handover", 64'(rise_cyc[k+1] - fall_cyc[f]), 64'd2);

    // Timeout: slave never acks m0.
    slave_en = 1'b0;
    k = rise_cyc.size();
    push_x(1, 0, 0, 32'h500, 32'h0, 32'h0);
    drive(0, 1'b1, 1'b1, 1'b0, 32'h500, 32'h0);
    e = -1;
    for (int t = 0; t < 40 && e < 0; t++) begin
      @(negedge clk);
      if (m_err_o != 2'b00) e = cyc_n;
    end
    check("t5_err_cycle", 64'(e), 64'(rise_cyc[k] + 15));
    @(posedge clk); #1;
    late_ack = 1'b1;
    @(negedge clk);
    check("t5_drain_scyc", {63'd0, s_cyc_o}, 64'd0);
    check("t5_drain_busy", {63'd0, busy_o}, 64'd1);
    check("t5_err_pulse", {62'd0, m_err_o}, 64'd0);
    @(posedge clk); #1;
    late_ack = 1'b0;
    drive(0, 1'b0, 1'b0, 1'b0, 32'h500, 32'h0);
    @(negedge clk);
    check("t5_drop_busy", {63'd0, busy_o}, 64'd1);
    @(negedge clk);
    check("t5_idle", {63'd0, busy_o}, 64'd0);

    // Reset while m1 owns a stalled transfer, then a tie goes to m0.
    @(posedge clk); #1;
    drive(1, 1'b1, 1'b1, 1'b0, 32'h40, 32'h0);
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    drive(0, 1'b1, 1'b1, 1'b0, 32'h80, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    r = cyc_n;
    @(negedge clk);
    check("t6_outputs", {m_rdata_o[31:0], 26'd0, m_ack_o, m_err_o, grant_o, busy_o}, 64'd0);
    check("t6_slave", {27'd0, s_cyc_o, s_stb_o, s_we_o, s_addr_o}, 64'd0);
    slave_en = 1'b1; slave_lat = 1; s_rdata_i = 32'h0000_6666;
    push_x(0, 0, 0, 32'h80, 32'h0, 32'h6666);
    push_x(0, 1, 0, 32'h40, 32'h0, 32'h6666);
    k = rise_cyc.size();
    fork
      mxfer(0, 32'h80, 1'b0, 32'h0, 1, ac);
      mxfer(1, 32'h40, 1'b0, 32'h0, 1, ac);
    join
    check("t6_tie_grant", 64'(rise_g[k]), 64'd0);
    check("t6_tie_cycle", 64'(rise_cyc[k]), 64'(r + 1));

    repeat (3) @(negedge clk);
    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
